fetch_controller: RTL and testbench

Instruction-fetch sequencer for the single-cycle/pipelined MIPS datapath. It owns the program counter and drives the address of the combinational instruction memory. Fetched words are queued with their PC in a small FIFO and handed to decode over a valid/ready handshake. It also handles stalls, control-flow redirects with flush, and fetch enable/disable.

---
 rtl/fetch_controller.sv | 94 +++++++++
 tb/tb_fetch_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, fetches from combinational imem and queues {instr, pc} for decode
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [2:0]  buf_count,
  output logic        err_misaligned
);
  localparam int         AW      = (BUF_DEPTH == 4) ? 2 : 1;
  localparam logic [2:0] DEPTH   = 3'(BUF_DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  logic [1:0]    r_state;
  logic [31:0]   r_pc;
  logic [31:0]   r_mem_instr [BUF_DEPTH];
  logic [31:0]   r_mem_pc [BUF_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [2:0]    r_count;
  logic [31:0]   r_out_instr;
  logic [31:0]   r_out_pc;
  logic          r_err;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_head_new;
  logic [2:0]    w_count_nx;
  logic [AW-1:0] w_rd_nx;
  logic [1:0]    w_state_nx;
  assign imem_addr      = r_pc;
  assign if_valid       = r_count != 3'd0;
  assign if_instr       = r_out_instr;
  assign if_pc          = r_out_pc;
  assign buf_count      = r_count;
  assign err_misaligned = r_err;
  // Handshake, push permission, next occupancy and next FSM state; a redirect overrides everything but the head pop
  always_comb begin
    w_full     = r_count == DEPTH;
    w_pop      = if_valid && if_ready;
    w_push     = r_state == S_RUN && fetch_en && !redirect_valid && (!w_full || w_pop);
    w_count_nx = redirect_valid ? 3'd0 : r_count + {2'b0, w_push} - {2'b0, w_pop};
    w_rd_nx    = r_rd + AW'(w_pop);
    w_head_new = w_push && r_count == {2'b0, w_pop};
    w_state_nx = redirect_valid ? (fetch_en ? S_RUN : S_IDLE) :
                 !fetch_en ? S_IDLE :
                 r_state == S_IDLE ? S_RUN :
                 r_state == S_STALL ? (w_pop ? S_RUN : S_STALL) :
                 (w_push && !w_pop && w_count_nx == DEPTH) ? S_STALL : S_RUN;
  end
  // FIFO storage needs no reset: occupancy alone decides which slots are meaningful
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr] <= imem_instr;
      r_mem_pc[r_wr]    <= r_pc;
    end
  end
  // PC, FSM, pointers, sticky error and the registered head copy presented to decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_rd        <= '0;
      r_wr        <= '0;
      r_count     <= 3'd0;
      r_out_instr <= 32'd0;
      r_out_pc    <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= redirect_valid ? {redirect_pc[31:2], 2'b00} : w_push ? r_pc + PC_STEP : r_pc;
      r_rd    <= redirect_valid ? '0 : w_rd_nx;
      r_wr    <= redirect_valid ? '0 : r_wr + AW'(w_push);
      r_count <= w_count_nx;
      r_err   <= r_err | (redirect_valid & |redirect_pc[1:0]);
      if (w_count_nx != 3'd0) begin
        r_out_instr <= w_head_new ? imem_instr : r_mem_instr[w_rd_nx];
        r_out_pc    <= w_head_new ? r_pc : r_mem_pc[w_rd_nx];
      end
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed vectors against two instances (default and wrapped RESET_PC with depth 4)
module tb_fetch_controller;
  typedef logic [100:0] vec_t;
  localparam logic [31:0] I0  = 32'h0109_4020;
  localparam logic [31:0] I4  = 32'h212A_0001;
  localparam logic [31:0] I8  = 32'h8BAD_F00D;
  localparam logic [31:0] WC  = 32'hA5A5_000C;
  localparam logic [31:0] W40 = 32'hA5A5_0040;
  localparam logic [31:0] W44 = 32'hA5A5_0044;
  localparam logic [31:0] WF8 = 32'h5A5A_FFF8;
  localparam logic [31:0] WFC = 32'h5A5A_FFFC;
  localparam logic [31:0] RB  = 32'hFFFF_FFF8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  logic        rst_n = 1'b1, fetch_en = 1'b0, redirect_valid = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr, imem_instr, if_instr, if_pc;
  logic        if_valid, err_misaligned;
  logic [2:0]  buf_count;
  logic        rst_n_b = 1'b1, fetch_en_b = 1'b0, if_ready_b = 1'b0;
  logic [31:0] imem_addr_b, imem_instr_b, if_instr_b, if_pc_b;
  logic        if_valid_b, err_misaligned_b;
  logic [2:0]  buf_count_b;
  vec_t obs_a, obs_b;
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   return I0;
      32'h4:   return I4;
      32'h8:   return I8;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction
  assign imem_instr   = mem(imem_addr);
  assign imem_instr_b = mem(imem_addr_b);
  assign obs_a = {err_misaligned, if_valid, buf_count, if_instr, if_pc, imem_addr};
  assign obs_b = {err_misaligned_b, if_valid_b, buf_count_b, if_instr_b, if_pc_b, imem_addr_b};
  fetch_controller dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .buf_count(buf_count), .err_misaligned(err_misaligned)
  );
  fetch_controller #(.RESET_PC(RB), .BUF_DEPTH(4), .PC_STEP(32'd4)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .fetch_en(fetch_en_b), .imem_addr(imem_addr_b), .imem_instr(imem_instr_b),
    .redirect_valid(1'b0), .redirect_pc(32'd0), .if_valid(if_valid_b), .if_ready(if_ready_b),
    .if_instr(if_instr_b), .if_pc(if_pc_b), .buf_count(buf_count_b), .err_misaligned(err_misaligned_b)
  );
  task automatic reset_a();
    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #2 rst_n = 1'b1;
  endtask
  task automatic reset_b();
    rst_n_b = 1'b0; fetch_en_b = 1'b0; if_ready_b = 1'b0;
    #2 rst_n_b = 1'b1;
  endtask
  task automatic test_reset();
    #1 rst_n = 1'b0; rst_n_b = 1'b0;
    #1;
    n_vec++;
    if (obs_a !== {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0}) begin n_err++; $display("FAIL reset_a: got %h want %h", obs_a, {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0}); end
    n_vec++;
    if (obs_b !== {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, RB}) begin n_err++; $display("FAIL reset_b: got %h want %h", obs_b, {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, RB}); end
    rst_n = 1'b1; rst_n_b = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_stream();
    logic [5:0] fen = 6'b001111;
    vec_t exp [6] = '{
      {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0},
      {1'b0, 1'b1, 3'd1, I0, 32'h0, 32'h4},
      {1'b0, 1'b1, 3'd1, I4, 32'h4, 32'h8},
      {1'b0, 1'b1, 3'd1, I8, 32'h8, 32'hC},
      {1'b0, 1'b0, 3'd0, I8, 32'h8, 32'hC},
      {1'b0, 1'b0, 3'd0, I8, 32'h8, 32'hC}};
    reset_a();
    for (int i = 0; i < 6; i++) begin
      fetch_en = fen[i]; if_ready = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (obs_a !== exp[i]) begin n_err++; $display("FAIL stream step %0d: got %h want %h", i, obs_a, exp[i]); end
    end
  endtask
  task automatic test_stall();
    logic [6:0] rdy = 7'b0010000;
    vec_t exp [7] = '{
      {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0},
      {1'b0, 1'b1, 3'd1, I0, 32'h0, 32'h4},
      {1'b0, 1'b1, 3'd2, I0, 32'h0, 32'h8},
      {1'b0, 1'b1, 3'd2, I0, 32'h0, 32'h8},
      {1'b0, 1'b1, 3'd1, I4, 32'h4, 32'h8},
      {1'b0, 1'b1, 3'd2, I4, 32'h4, 32'hC},
      {1'b0, 1'b1, 3'd2, I4, 32'h4, 32'hC}};
    reset_a();
    for (int i = 0; i < 7; i++) begin
      fetch_en = 1'b1; if_ready = rdy[i];
      @(posedge clk); #1;
      n_vec++;
      if (obs_a !== exp[i]) begin n_err++; $display("FAIL stall step %0d: got %h want %h", i, obs_a, exp[i]); end
    end
  endtask
  task automatic test_redirect();
    logic [4:0] rdy = 5'b01000;
    vec_t exp [5] = '{
      {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0},
      {1'b0, 1'b1, 3'd1, I0, 32'h0, 32'h4},
      {1'b0, 1'b1, 3'd2, I0, 32'h0, 32'h8},
      {1'b0, 1'b0, 3'd0, I0, 32'h0, 32'h40},
      {1'b0, 1'b1, 3'd1, W40, 32'h40, 32'h44}};
    reset_a();
    for (int i = 0; i < 5; i++) begin
      fetch_en = 1'b1; if_ready = rdy[i]; redirect_valid = rdy[i]; redirect_pc = 32'h40;
      @(posedge clk); #1;
      n_vec++;
      if (obs_a !== exp[i]) begin n_err++; $display("FAIL redirect step %0d: got %h want %h", i, obs_a, exp[i]); end
    end
  endtask
  task automatic test_misaligned();
    vec_t exp [3] = '{
      {1'b1, 1'b0, 3'd0, W40, 32'h40, 32'h40},
      {1'b1, 1'b1, 3'd1, W40, 32'h40, 32'h44},
      {1'b1, 1'b1, 3'd1, W44, 32'h44, 32'h48}};
    for (int i = 0; i < 3; i++) begin
      fetch_en = 1'b1; if_ready = 1'b1; redirect_valid = i == 0; redirect_pc = 32'h43;
      @(posedge clk); #1;
      n_vec++;
      if (obs_a !== exp[i]) begin n_err++; $display("FAIL misaligned step %0d: got %h want %h", i, obs_a, exp[i]); end
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs_a !== {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0}) begin n_err++; $display("FAIL misaligned_clear: got %h want %h", obs_a, {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_drain();
    logic [9:0] fen = 10'b0000000111;
    logic [9:0] rdy = 10'b0011100000;
    logic [9:0] red = 10'b0100000000;
    vec_t exp [10] = '{
      {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0},
      {1'b0, 1'b1, 3'd1, I0, 32'h0, 32'h4},
      {1'b0, 1'b1, 3'd2, I0, 32'h0, 32'h8},
      {1'b0, 1'b1, 3'd2, I0, 32'h0, 32'h8},
      {1'b0, 1'b1, 3'd2, I0, 32'h0, 32'h8},
      {1'b0, 1'b1, 3'd1, I4, 32'h4, 32'h8},
      {1'b0, 1'b0, 3'd0, I4, 32'h4, 32'h8},
      {1'b0, 1'b0, 3'd0, I4, 32'h4, 32'h8},
      {1'b0, 1'b0, 3'd0, I4, 32'h4, 32'h100},
      {1'b0, 1'b0, 3'd0, I4, 32'h4, 32'h100}};
    reset_a();
    for (int i = 0; i < 10; i++) begin
      fetch_en = fen[i]; if_ready = rdy[i]; redirect_valid = red[i]; redirect_pc = 32'h100;
      @(posedge clk); #1;
      n_vec++;
      if (obs_a !== exp[i]) begin n_err++; $display("FAIL drain step %0d: got %h want %h", i, obs_a, exp[i]); end
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] fen = 8'b11110111;
    logic [7:0] rdy = 8'b11100000;
    vec_t exp [8] = '{
      {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0},
      {1'b0, 1'b1, 3'd1, I0, 32'h0, 32'h4},
      {1'b0, 1'b1, 3'd2, I0, 32'h0, 32'h8},
      {1'b0, 1'b1, 3'd2, I0, 32'h0, 32'h8},
      {1'b0, 1'b1, 3'd2, I0, 32'h0, 32'h8},
      {1'b0, 1'b1, 3'd2, I4, 32'h4, 32'hC},
      {1'b0, 1'b1, 3'd2, I8, 32'h8, 32'h10},
      {1'b0, 1'b1, 3'd2, WC, 32'hC, 32'h14}};
    reset_a();
    for (int i = 0; i < 8; i++) begin
      fetch_en = fen[i]; if_ready = rdy[i];
      @(posedge clk); #1;
      n_vec++;
      if (obs_a !== exp[i]) begin n_err++; $display("FAIL back_to_back step %0d: got %h want %h", i, obs_a, exp[i]); end
    end
  endtask
  task automatic test_wrap();
    vec_t exp [4] = '{
      {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, RB},
      {1'b0, 1'b1, 3'd1, WF8, RB, 32'hFFFF_FFFC},
      {1'b0, 1'b1, 3'd1, WFC, 32'hFFFF_FFFC, 32'h0},
      {1'b0, 1'b1, 3'd1, I0, 32'h0, 32'h4}};
    vec_t fill [6] = '{
      {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, RB},
      {1'b0, 1'b1, 3'd1, WF8, RB, 32'hFFFF_FFFC},
      {1'b0, 1'b1, 3'd2, WF8, RB, 32'h0},
      {1'b0, 1'b1, 3'd3, WF8, RB, 32'h4},
      {1'b0, 1'b1, 3'd4, WF8, RB, 32'h8},
      {1'b0, 1'b1, 3'd4, WF8, RB, 32'h8}};
    reset_b();
    for (int i = 0; i < 4; i++) begin
      fetch_en_b = 1'b1; if_ready_b = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (obs_b !== exp[i]) begin n_err++; $display("FAIL wrap step %0d: got %h want %h", i, obs_b, exp[i]); end
    end
    #1 rst_n_b = 1'b0;
    #1;
    n_vec++;
    if (obs_b !== {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, RB}) begin n_err++; $display("FAIL async_reset: got %h want %h", obs_b, {1'b0, 1'b0, 3'd0, 32'h0, 32'h0, RB}); end
    @(posedge clk); #1;
    reset_b();
    for (int i = 0; i < 6; i++) begin
      fetch_en_b = 1'b1; if_ready_b = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if (obs_b !== fill[i]) begin n_err++; $display("FAIL depth4 step %0d: got %h want %h", i, obs_b, fill[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_drain();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
